// File: rtl/switch_debounce_pkg.sv
// rtl/switch_debounce_pkg.sv - shared FSM state type and default debounce length for switch_debounce
package switch_debounce_pkg;

    // 10 ms of stable input at a 25 MHz clock
    localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - one debounce channel: 2-flop sync, settle FSM, counter, optional press pulse (DEBOUNCE_PRESS_PULSE_EN)
module debounce_filter
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [1:0]       sync_q;
    logic             synced;
    deb_state_t       state;
    logic [CNT_W-1:0] count;
    logic             level_q;

    assign synced   = sync_q[1];
    assign o_Switch = level_q;

    // Two-stage synchronizer; the raw pin is never used anywhere else
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_Switch};
        end
    end

    // Settle FSM: an input must hold its new level for DEBOUNCE_LIMIT
    // consecutive synced cycles after the first deviation before the output follows
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state   <= STABLE_LOW;
            count   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state)
                STABLE_LOW: begin
                    if (synced) begin
                        state <= WAIT_HIGH;
                        count <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!synced) begin
                        state <= STABLE_LOW;
                        count <= '0;
                    end else if (count == LAST_COUNT) begin
                        state   <= STABLE_HIGH;
                        count   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!synced) begin
                        state <= WAIT_LOW;
                        count <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (synced) begin
                        state <= STABLE_HIGH;
                        count <= '0;
                    end else if (count == LAST_COUNT) begin
                        state   <= STABLE_LOW;
                        count   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= STABLE_LOW;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_PRESS_PULSE_EN
    logic press_q;

    // Pulse on exactly the edge where the debounced level goes 0->1
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            press_q <= 1'b0;
        end else begin
            press_q <= (state == WAIT_HIGH) && synced && (count == LAST_COUNT);
        end
    end

    assign o_Press = press_q;
`else
    assign o_Press = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two independent debounced push-button channels; press pulses under DEBOUNCE_PRESS_PULSE_EN
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Switch_1,
    output logic o_Switch_2,
    output logic o_Press_1,
    output logic o_Press_2
);

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter_1 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_1),
        .o_Switch (o_Switch_1),
        .o_Press  (o_Press_1)
    );

    debounce_filter #(
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_filter_2 (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch_2),
        .o_Switch (o_Switch_2),
        .o_Press  (o_Press_2)
    );

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed and randomized checks of switch_debounce against a run-length model
module tb_switch_debounce;

    localparam int LIMIT = 4;

    logic i_Clk = 1'b0;
    logic i_Rst;
    logic i_Switch_1;
    logic i_Switch_2;
    logic o_Switch_1;
    logic o_Switch_2;
    logic o_Press_1;
    logic o_Press_2;

    int checks   = 0;
    int failures = 0;

    always #5 i_Clk = ~i_Clk;

    switch_debounce #(
        .DEBOUNCE_LIMIT(LIMIT)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Switch_1 (i_Switch_1),
        .i_Switch_2 (i_Switch_2),
        .o_Switch_1 (o_Switch_1),
        .o_Switch_2 (o_Switch_2),
        .o_Press_1  (o_Press_1),
        .o_Press_2  (o_Press_2)
    );

    // Reference: raw level reaches the filter two edges late; the output
    // follows once the seen level has disagreed with it for LIMIT+1 edges in a row.
    bit m_d1[2];
    bit m_d2[2];
    bit m_out[2];
    bit m_press[2];
    int m_run[2];

    function automatic void model_edge(int ch, bit raw, bit rst);
        if (rst) begin
            m_d1[ch] = 0; m_d2[ch] = 0; m_out[ch] = 0; m_press[ch] = 0; m_run[ch] = 0;
            return;
        end
        m_press[ch] = 0;
        if (m_d2[ch] != m_out[ch]) begin
            m_run[ch]++;
            if (m_run[ch] == LIMIT + 1) begin
                m_out[ch]   = m_d2[ch];
                m_press[ch] = m_d2[ch];
                m_run[ch]   = 0;
            end
        end else begin
            m_run[ch] = 0;
        end
        m_d2[ch] = m_d1[ch];
        m_d1[ch] = raw;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic press_exp(int ch);
`ifdef DEBOUNCE_PRESS_PULSE_EN
        return m_press[ch];
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge: advance the model with what was driven, then compare
    task automatic step();
        @(posedge i_Clk);
        model_edge(0, i_Switch_1, i_Rst);
        model_edge(1, i_Switch_2, i_Rst);
        #1;
        check("model_sw1", o_Switch_1, m_out[0]);
        check("model_sw2", o_Switch_2, m_out[1]);
        check("model_press1", o_Press_1, press_exp(0));
        check("model_press2", o_Press_2, press_exp(1));
    endtask

    task automatic do_reset();
        i_Rst = 1'b1; i_Switch_1 = 1'b0; i_Switch_2 = 1'b0;
        step(); step();
        i_Rst = 1'b0;
    endtask

    function automatic logic rise_press(int i);
`ifdef DEBOUNCE_PRESS_PULSE_EN
        return logic'(i == LIMIT + 2);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        int hold1;
        int hold2;

        // Reset state
        do_reset();
        check("reset_sw1", o_Switch_1, 1'b0);
        check("reset_sw2", o_Switch_2, 1'b0);
        check("reset_press1", o_Press_1, 1'b0);
        check("reset_press2", o_Press_2, 1'b0);

        // Single clean press on channel 1: rises at edge LIMIT+2
        i_Switch_1 = 1'b1;
        for (int i = 0; i <= LIMIT + 2; i++) begin
            step();
            check("press_rise_sw1", o_Switch_1, logic'(i == LIMIT + 2));
            check("press_rise_pulse1", o_Press_1, rise_press(i));
            check("press_rise_sw2", o_Switch_2, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check("press_hold_sw1", o_Switch_1, 1'b1);
            check("press_hold_pulse1", o_Press_1, 1'b0);
        end

        // Chatter while high, then a clean release falls at edge LIMIT+2 with no pulse
        for (int i = 0; i < 20; i++) begin
            i_Switch_1 = ~i_Switch_1;
            step();
            check("chatter_sw1", o_Switch_1, 1'b1);
        end
        i_Switch_1 = 1'b0;
        for (int i = 0; i <= LIMIT + 2; i++) begin
            step();
            check("release_sw1", o_Switch_1, logic'(i != LIMIT + 2));
            check("release_pulse1", o_Press_1, 1'b0);
        end

        // Bounce of 3 cycles never reaches the output; clean hold rises later
        do_reset();
        i_Switch_1 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        i_Switch_1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bounce_sw1", o_Switch_1, 1'b0);
        end
        i_Switch_1 = 1'b1;
        for (int i = 0; i <= LIMIT + 2; i++) begin
            step();
            check("rebounce_sw1", o_Switch_1, logic'(i == LIMIT + 2));
        end

        // Simultaneous press on both channels
        do_reset();
        i_Switch_1 = 1'b1; i_Switch_2 = 1'b1;
        for (int i = 0; i <= LIMIT + 2; i++) begin
            step();
            check("both_sw1", o_Switch_1, logic'(i == LIMIT + 2));
            check("both_sw2", o_Switch_2, logic'(i == LIMIT + 2));
        end

        // Reset part-way through the count restarts the full wait
        do_reset();
        i_Switch_1 = 1'b1;
        for (int i = 0; i < 5; i++) step();
        i_Rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("midreset_sw1", o_Switch_1, 1'b0);
            check("midreset_press1", o_Press_1, 1'b0);
        end
        i_Rst = 1'b0;
        for (int i = 0; i <= LIMIT + 2; i++) begin
            step();
            check("postreset_sw1", o_Switch_1, logic'(i == LIMIT + 2));
        end

        // Randomized levels with random hold lengths and rare resets
        do_reset();
        hold1 = 0;
        hold2 = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold1 == 0) begin
                i_Switch_1 = 1'($urandom_range(0, 1));
                hold1 = $urandom_range(1, 2 * LIMIT + 4);
            end
            if (hold2 == 0) begin
                i_Switch_2 = 1'($urandom_range(0, 1));
                hold2 = $urandom_range(1, 2 * LIMIT + 4);
            end
            i_Rst = ($urandom_range(0, 99) == 0);
            step();
            hold1--;
            hold2--;
        end
        i_Rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter: DEBOUNCE_LIMIT, default 250000, stable cycles required before output changes (10 ms at 25 MHz); legal range >= 2.
REQ-002 Port: i_Clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: i_Rst  input  1  synchronous, active-high reset.
REQ-004 Port: i_Switch_1  input  1  raw asynchronous push-button level, channel 1.
REQ-005 Port: i_Switch_2  input  1  raw asynchronous push-button level, channel 2.
REQ-006 Port: o_Switch_1  output  1  debounced level, channel 1; feeds downstream LED gate logic.
REQ-007 Port: o_Switch_2  output  1  debounced level, channel 2; feeds downstream LED gate logic.
REQ-008 Port: o_Press_1  output  1  one-cycle press pulse, channel 1.
REQ-009 Port: o_Press_2  output  1  one-cycle press pulse, channel 2.
REQ-010 One clock (i_Clk); reset i_Rst is synchronous and active-high.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer before any other use; no combinational path from i_Switch_n to any output.
REQ-012 Each channel SHALL run an independent FSM: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-013 STABLE_LOW: synced input 1 -> WAIT_HIGH, counter cleared to 0; else stay.
REQ-014 WAIT_HIGH: synced input 0 -> STABLE_LOW, counter cleared, o_Switch_n unchanged; synced 1 and counter == DEBOUNCE_LIMIT-1 -> STABLE_HIGH, o_Switch_n <= 1; else counter +1.
REQ-015 STABLE_HIGH / WAIT_LOW SHALL mirror REQ-013/014 with polarity inverted, ending in STABLE_LOW with o_Switch_n <= 0.
REQ-016 Counter width SHALL be $clog2(DEBOUNCE_LIMIT); counter SHALL never exceed DEBOUNCE_LIMIT-1 and never wrap.
REQ-017 Latency: clean edge first sampled at clock edge k SHALL update o_Switch_n at edge k+DEBOUNCE_LIMIT+2.
REQ-018 Any glitch shorter than DEBOUNCE_LIMIT synced cycles SHALL leave o_Switch_n unchanged and restart the count on the next deviation.
REQ-019 o_Switch_n SHALL be registered and change only on an FSM transition into a STABLE state.
REQ-020 Channels SHALL be fully independent; simultaneous edges on both inputs produce simultaneous, identical-latency outputs.

Reset
REQ-021 While i_Rst=1 at a clock edge: synchronizers 0, FSM STABLE_LOW, counter 0, o_Switch_n 0, o_Press_n 0.
REQ-022 Reset asserted mid-WAIT SHALL abort the count; after release, a held-high input SHALL require a full DEBOUNCE_LIMIT+2 cycles before o_Switch_n rises.

Configuration
REQ-023 Macro DEBOUNCE_PRESS_PULSE_EN defined: o_Press_n SHALL be registered, high for exactly the one cycle in which o_Switch_n transitions 0->1 (same edge).
REQ-024 Macro DEBOUNCE_PRESS_PULSE_EN undefined: o_Press_n SHALL be tied constant 0 and no pulse logic synthesized; ports remain present.

Structure
REQ-025 Shared package switch_debounce_pkg SHALL hold the FSM state typedef (4 states, 2 bits) and DEBOUNCE_LIMIT default constant.
REQ-026 Per-channel logic SHALL live in one sub-module debounce_filter (sync + FSM + counter + optional pulse), instantiated twice by switch_debounce.

Verification (bench uses DEBOUNCE_LIMIT=4)
REQ-027 Reset then i_Switch_1 0->1 held before edge 0 -> o_Switch_1 rises at edge 6, o_Switch_2 stays 0.
REQ-028 i_Switch_1 high for 3 cycles then low (bounce) -> o_Switch_1 never rises; clean hold thereafter -> rises 6 edges after re-assertion.
REQ-029 With DEBOUNCE_PRESS_PULSE_EN: clean press -> o_Press_1 high exactly one cycle, coincident with o_Switch_1 0->1; release -> no pulse; without macro o_Press_1 constant 0.
REQ-030 Both switches asserted same cycle -> o_Switch_1 and o_Switch_2 rise on same edge (edge 6).
REQ-031 i_Rst pulsed at count 2 of WAIT_HIGH with input held 1 -> outputs 0 during reset; o_Switch_1 rises 6 edges after reset release.
REQ-032 o_Switch_1 high, i_Switch_1 0->1->0 toggling every cycle for 20 cycles -> o_Switch_1 remains 1; held 0 -> falls at edge 6.
